sprite_palette_lut: RTL and testbench
=====================================

SPRITE_PALETTE_LUT -- requirements
Module: sprite_palette_lut

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, palette index width (2^IDX_W entries per bank).
REQ-002 The block SHALL have parameter CH_W, default 4, bits per colour channel.
REQ-003 The block SHALL have parameter TRANSP_IDX, default 0, the index flagged as transparent.
REQ-004 Clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 pix_valid_in  in  1  lookup request qualifier.
REQ-007 pix_index  in  IDX_W  palette index to look up.
REQ-008 wr_en  in  1  shadow-bank write strobe.
REQ-009 wr_addr  in  IDX_W  shadow entry address.
REQ-010 wr_data  in  3*CH_W  {red, green, blue} entry value.
REQ-011 swap_req  in  1  single-cycle request to exchange active and shadow banks.
REQ-012 fade_level  in  4  dim amount, 0 = full brightness (present only with PALETTE_FADE_EN).
REQ-013 pix_valid_out  out  1  output qualifier.
REQ-014 red, green, blue  out  CH_W each  looked-up colour.
REQ-015 transparent  out  1  output pixel index equalled TRANSP_IDX.
REQ-016 swap_pending  out  1  swap requested, not yet executed.

Function
REQ-017 The block SHALL hold two banks of 2^IDX_W entries of 3*CH_W bits in registers, one active (read by lookups) and one shadow (target of writes), selected by a 1-bit bank select.
REQ-018 Lookup latency SHALL be exactly 2 cycles: stage 1 registers active-bank entry, index compare and fade_level; stage 2 registers fade result, transparent and valid.
REQ-019 pix_valid_out SHALL equal pix_valid_in delayed 2 cycles; one result per cycle, no stalls, no backpressure.
REQ-020 When pix_valid_out is 0, red, green, blue and transparent SHALL be 0.
REQ-021 transparent SHALL be 1 with a valid output whose index equalled TRANSP_IDX; colour still driven from the entry.
REQ-022 wr_en SHALL write wr_data to shadow[wr_addr] at the clock edge; writes never affect lookups in flight.
REQ-023 swap_req SHALL set swap_pending; repeated requests while pending SHALL merge into one swap.
REQ-024 The swap SHALL execute (bank select toggles, swap_pending clears) on the first edge where swap_pending or swap_req is 1, pix_valid_in is 0 and both pipeline stages are empty.
REQ-025 Lookups issued before the swap edge SHALL use the old active bank; lookups issued after SHALL use the new one.
REQ-026 wr_en coincident with the swap edge SHALL write the pre-swap shadow bank (which becomes active).
REQ-027 After a swap, the new shadow bank SHALL contain the previous active contents, unmodified.
REQ-028 Channel arithmetic: output = (ch * (16 - fade_level)) >> 4, product held in CH_W+5 bits, result truncated to CH_W.

Reset
REQ-029 Reset SHALL load bank 0 entry i with each channel equal to i zero-extended or truncated to CH_W, clear bank 1 to 0, and select bank 0 as active.
REQ-030 Reset SHALL clear both pipeline stages, swap_pending and all outputs to 0 on the following cycle, discarding in-flight lookups and pending swaps.

Configuration
REQ-031 With macro PALETTE_FADE_EN defined, port fade_level and REQ-028 scaling SHALL be present.
REQ-032 Without PALETTE_FADE_EN, fade_level SHALL be absent and output channels SHALL equal the entry channels unmodified, latency still 2.

Verification (IDX_W=4, CH_W=4)
REQ-033 Reset, then pix_index=5 valid for 1 cycle -> 2 cycles later pix_valid_out=1, rgb=5,5,5, transparent=0.
REQ-034 wr_en addr 3 data 0xF00, swap_req with idle pipeline -> swap_pending clears next edge; lookup index 3 returns F,0,0.
REQ-035 swap_req during continuous 10-cycle valid stream -> swap_pending stays 1 until stream ends plus 2 empty cycles; all 10 pixels from old bank.
REQ-036 PALETTE_FADE_EN, entry 15 = 0xFFF, fade_level=8 -> rgb=7,7,7; fade_level=0 -> F,F,F.
REQ-037 pix_index=0 -> transparent=1 with rgb=0,0,0; Reset asserted mid-stream -> pix_valid_out=0 next cycle, bank 0 grey ramp restored.

Source files
------------

// File: rtl/sprite_palette_lut.sv
// -----------------------------------------------------------------------------
// sprite_palette_lut
//
// Double-buffered sprite palette lookup with a fixed 2-cycle pipeline.
// Lookups read the active bank. Writes always go to the shadow bank. A swap
// request exchanges the two banks, but only while the pipeline is empty, so
// every pixel in flight completes against the bank it was issued to.
//
// Optional feature (macro PALETTE_FADE_EN):
//   Adds the fade_level port and scales each channel by (16 - fade_level)/16.
//   Without the macro the channels pass through unmodified, and the latency is
//   still 2 cycles.
//
// Parameters
//   IDX_W       palette index width (2**IDX_W entries per bank)
//   CH_W        bits per colour channel
//   TRANSP_IDX  palette index reported as transparent
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   pix_valid_in   lookup request qualifier
//   pix_index      palette index to look up
//   wr_en          shadow-bank write strobe
//   wr_addr        shadow entry address
//   wr_data        {red, green, blue} entry value
//   swap_req       single-cycle request to exchange active/shadow banks
//   fade_level     dim amount, 0 = full brightness (PALETTE_FADE_EN only)
//   pix_valid_out  output qualifier (pix_valid_in delayed 2 cycles)
//   red/green/blue looked-up colour, 0 when pix_valid_out is 0
//   transparent    output pixel index equalled TRANSP_IDX
//   swap_pending   swap requested but not yet executed
// -----------------------------------------------------------------------------
module sprite_palette_lut #(
  parameter int IDX_W      = 4,
  parameter int CH_W       = 4,
  parameter int TRANSP_IDX = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid_in,
  input  logic [IDX_W-1:0]  pix_index,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_data,
  input  logic              swap_req,
`ifdef PALETTE_FADE_EN
  input  logic [3:0]        fade_level,
`endif
  output logic              pix_valid_out,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transparent,
  output logic              swap_pending
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int ENT_W = 3 * CH_W;

  // Two register banks; bank_sel names the active one, ~bank_sel the shadow.
  logic [ENT_W-1:0] bank [2][DEPTH];
  logic             bank_sel;

  // Stage 1: captured entry, transparency compare and fade amount.
  logic             s1_valid;
  logic [ENT_W-1:0] s1_entry;
  logic             s1_transp;
  logic [3:0]       s1_fade;

  // Channel values after the optional fade, feeding stage 2.
  logic [CH_W-1:0]  ch_r, ch_g, ch_b;

  // The swap waits for an idle input and two empty stages, so no lookup can
  // straddle the bank change.
  logic swap_go;
  assign swap_go = (swap_pending | swap_req) & ~pix_valid_in & ~s1_valid & ~pix_valid_out;

`ifdef PALETTE_FADE_EN
  localparam int PROD_W = CH_W + 5;

  // (ch * (16 - lvl)) >> 4. The product fits in CH_W+5 bits. Only the low CH_W
  // bits of the shifted value are kept.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] ch,
                                              input logic [3:0]      lvl);
    logic [PROD_W-1:0] prod;
    prod    = PROD_W'(ch) * (PROD_W'(16) - PROD_W'(lvl));
    fade_ch = CH_W'(prod >> 4);
  endfunction
`endif

  always_comb begin
    ch_r = s1_entry[3*CH_W-1:2*CH_W];
    ch_g = s1_entry[2*CH_W-1:CH_W];
    ch_b = s1_entry[CH_W-1:0];
`ifdef PALETTE_FADE_EN
    ch_r = fade_ch(s1_entry[3*CH_W-1:2*CH_W], s1_fade);
    ch_g = fade_ch(s1_entry[2*CH_W-1:CH_W],   s1_fade);
    ch_b = fade_ch(s1_entry[CH_W-1:0],        s1_fade);
`endif
  end

  // Palette storage, bank select and swap handshake.
  // NOTE: these register banks are reset on purpose, because the palette must
  // come out of reset holding a known grey ramp. A plain RAM would not be reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[0][i] <= {3{CH_W'(i)}};
        bank[1][i] <= '0;
      end
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      // The write uses the pre-swap bank_sel. A write on the swap edge
      // therefore lands in the bank that is about to become active.
      if (wr_en) bank[~bank_sel][wr_addr] <= wr_data;
      if (swap_go) begin
        bank_sel     <= ~bank_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Two-stage lookup pipeline.
  // NOTE: all state here uses non-blocking assignments. Each stage then reads
  // the value the previous stage held before the edge, which gives exactly one
  // cycle per stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_entry      <= '0;
      s1_transp     <= 1'b0;
      s1_fade       <= '0;
      pix_valid_out <= 1'b0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
      transparent   <= 1'b0;
    end else begin
      // An invalid request captures zeros. The outputs are then 0 whenever
      // pix_valid_out is 0, with no extra gating in stage 2.
      s1_valid  <= pix_valid_in;
      s1_entry  <= pix_valid_in ? bank[bank_sel][pix_index] : '0;
      s1_transp <= pix_valid_in && (pix_index == IDX_W'(TRANSP_IDX));
`ifdef PALETTE_FADE_EN
      s1_fade   <= pix_valid_in ? fade_level : 4'd0;
`else
      s1_fade   <= 4'd0;
`endif
      pix_valid_out <= s1_valid;
      red           <= ch_r;
      green         <= ch_g;
      blue          <= ch_b;
      transparent   <= s1_transp;
    end
  end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// -----------------------------------------------------------------------------
// tb_sprite_palette_lut
//
// Scoreboard bench. The driver applies one stimulus per cycle at the falling
// edge. It updates a reference palette model that holds an "active" array and
// a "shadow" array and exchanges their contents on a swap. Expected pixels are
// pushed into a queue. A monitor samples the DUT 1 time unit after each rising
// edge and pops and compares whenever pix_valid_out is high.
// -----------------------------------------------------------------------------
module tb_sprite_palette_lut;

  localparam int IDX_W = 4;
  localparam int CH_W  = 4;
  localparam int DEPTH = 16;
`ifdef PALETTE_FADE_EN
  localparam bit FADE_ON = 1'b1;
`else
  localparam bit FADE_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              pix_valid_in;
  logic [IDX_W-1:0]  pix_index;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [3*CH_W-1:0] wr_data;
  logic              swap_req;
  logic [3:0]        fade_level;
  logic              pix_valid_out;
  logic [CH_W-1:0]   red, green, blue;
  logic              transparent;
  logic              swap_pending;

  always #5 clk = ~clk;

  sprite_palette_lut #(.IDX_W(IDX_W), .CH_W(CH_W), .TRANSP_IDX(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .pix_valid_in  (pix_valid_in),
    .pix_index     (pix_index),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .swap_req      (swap_req),
`ifdef PALETTE_FADE_EN
    .fade_level    (fade_level),
`endif
    .pix_valid_out (pix_valid_out),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .transparent   (transparent),
    .swap_pending  (swap_pending)
  );

  typedef struct {
    int r;
    int g;
    int b;
    int t;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] act_pal [DEPTH];
  logic [11:0] shd_pal [DEPTH];
  bit          m_pend, v1, v2;
  bit          exp_pend, exp_vout;
  bit          mon_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int fade_m(input int ch, input int f);
    return FADE_ON ? (ch * (16 - f)) / 16 : ch;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      act_pal[i] = {4'(i), 4'(i), 4'(i)};
      shd_pal[i] = 12'h000;
    end
    m_pend = 1'b0;
    v1     = 1'b0;
    v2     = 1'b0;
    exp_q.delete();
  endtask

  // One cycle of stimulus, plus the reference model's view of the next edge.
  task automatic cycle(input bit v, input int idx, input bit we, input int wa,
                       input int wd, input bit sw, input int fd, input bit rs);
    exp_t        e;
    bit          go;
    logic [11:0] tmp;
    @(negedge clk);
    reset        = rs;
    pix_valid_in = v;
    pix_index    = 4'(idx);
    wr_en        = we;
    wr_addr      = 4'(wa);
    wr_data      = 12'(wd);
    swap_req     = sw;
    fade_level   = 4'(fd);
    if (rs) begin
      model_reset();
      exp_vout = 1'b0;
    end else begin
      exp_vout = v1;
      if (v) begin
        e.r = fade_m(int'(act_pal[idx][11:8]), fd);
        e.g = fade_m(int'(act_pal[idx][7:4]), fd);
        e.b = fade_m(int'(act_pal[idx][3:0]), fd);
        e.t = (idx == 0) ? 1 : 0;
        exp_q.push_back(e);
      end
      go = (m_pend || sw) && !v && !v1 && !v2;
      if (we) shd_pal[wa] = 12'(wd);
      if (go) begin
        for (int i = 0; i < DEPTH; i++) begin
          tmp        = act_pal[i];
          act_pal[i] = shd_pal[i];
          shd_pal[i] = tmp;
        end
        m_pend = 1'b0;
      end else if (sw) begin
        m_pend = 1'b1;
      end
      v2 = v1;
      v1 = v;
    end
    exp_pend = m_pend;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int idx, input int fd);
    cycle(1, idx, 0, 0, 0, 0, fd, 0);
  endtask

  // Monitor: checks the swap flag and qualifier every cycle, and pops and
  // compares pixel data whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check("swap_pending", 32'(swap_pending), 32'(exp_pend));
        check("pix_valid_out", 32'(pix_valid_out), 32'(exp_vout));
        if (pix_valid_out === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", 32'(pix_valid_out), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("red", 32'(red), 32'(e.r));
            check("green", 32'(green), 32'(e.g));
            check("blue", 32'(blue), 32'(e.b));
            check("transparent", 32'(transparent), 32'(e.t));
          end
        end else begin
          check("idle_outputs_zero", {19'd0, red, green, blue, transparent}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pix_valid_in = 0; pix_index = 0; wr_en = 0;
    wr_addr = 0; wr_data = 0; swap_req = 0; fade_level = 0;
    exp_pend = 0; exp_vout = 0;
    model_reset();

    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    mon_en = 1'b1;
    idle(2);

    // Grey ramp lookup, then the transparent index.
    pix(5, 0);
    idle(3);
    pix(0, 0);
    idle(3);

    // Shadow write, swap with an idle pipeline, lookup from the new bank.
    cycle(0, 0, 1, 3, 'hF00, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    pix(3, 0);
    pix(4, 0);
    idle(3);

    // Swap requested mid-stream: it waits for the stream plus 2 empty cycles.
    for (int i = 0; i < 10; i++)
      cycle(1, i, 0, 0, 0, (i == 2 || i == 6) ? 1'b1 : 1'b0, 0, 0);
    idle(4);
    pix(3, 0);  // swapped back: the ramp entry 3 is intact
    idle(3);

    // Fade scaling on a full-scale entry (pass-through without the macro).
    // The write coincides with the swap edge, so it lands in the bank that
    // becomes active.
    cycle(0, 0, 1, 15, 'hFFF, 1, 0, 0);
    pix(15, 8);
    pix(15, 0);
    pix(15, 15);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 15),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 15),
            $urandom_range(0, 4095), ($urandom_range(0, 9) == 0),
            $urandom_range(0, 15), 0);
    idle(3);

    // Reset in the middle of a stream with a swap pending.
    pix(1, 0);
    cycle(1, 2, 0, 0, 0, 1, 0, 0);
    pix(3, 0);
    cycle(1, 4, 0, 0, 0, 0, 0, 1);
    pix(7, 0);
    pix(0, 0);
    idle(4);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
